// File: rtl/ssm_tile_scheduler.sv
`default_nettype none
// ============================================================================
// Module   : ssm_tile_scheduler
// Purpose  : Walks the H x P head/channel space of the tiled FP16 SSM datapath
//            in H_tile x P_tile tiles. For each tile it pulses tile_start to
//            the tile engine, waits for tile_done, then moves to the next
//            tile (channels inner loop, heads outer loop). A full pass is
//            bracketed by busy and ends with a one-cycle done pulse.
// Ports    : clk        - clock, rising edge
//            rst        - asynchronous reset, active low
//            start      - begin a full pass (only looked at while idle)
//            abort      - cancel the current pass
//            tile_done  - engine pulse: current tile finished
//            tile_start - pulse to engine: compute tile at h_base/p_base
//            h_base     - first head index of the current tile
//            p_base     - first channel index of the current tile
//            tile_cnt   - tiles completed in this pass
//            busy       - pass in progress
//            done       - one-cycle pulse at pass completion
//            err        - sticky watchdog error
// Options  : SSM_TILE_TIMEOUT_EN - builds a per-tile watchdog of TIMEOUT_CYC
//            cycles; without it err is constant 0 and tiles wait forever.
// Revision : 1.0 - initial release
// ============================================================================
module ssm_tile_scheduler #(
  parameter int H           = 24,
  parameter int P           = 64,
  parameter int H_tile      = 12,
  parameter int P_tile      = 16,
  parameter int TIMEOUT_CYC = 4096,
  localparam int NT = (H / H_tile) * (P / P_tile),
  localparam int HW = $clog2(H),
  localparam int PW = $clog2(P),
  localparam int CW = $clog2(NT + 1)
) (
  input  logic          clk,
  input  logic          rst,
  input  logic          start,
  input  logic          abort,
  input  logic          tile_done,
  output logic          tile_start,
  output logic [HW-1:0] h_base,
  output logic [PW-1:0] p_base,
  output logic [CW-1:0] tile_cnt,
  output logic          busy,
  output logic          done,
  output logic          err
);

  localparam logic [HW-1:0] H_STEP   = HW'(H_tile);
  localparam logic [PW-1:0] P_STEP   = PW'(P_tile);
  localparam logic [PW-1:0] P_LAST   = PW'(P - P_tile);
  localparam logic [CW-1:0] CNT_LAST = CW'(NT - 1);

  typedef enum logic [1:0] {
    S_IDLE = 2'd0,
    S_WAIT = 2'd1,
    S_FIN  = 2'd2
  } state_t;

  state_t        state_q,      state_d;
  logic          tile_start_q, tile_start_d;
  logic [HW-1:0] h_base_q,     h_base_d;
  logic [PW-1:0] p_base_q,     p_base_d;
  logic [CW-1:0] tile_cnt_q,   tile_cnt_d;
  logic          busy_q,       busy_d;
  logic          done_q,       done_d;

`ifdef SSM_TILE_TIMEOUT_EN
  localparam int            WW      = $clog2(TIMEOUT_CYC + 1);
  // Compared against the count before increment, so the error fires on the
  // TIMEOUT_CYC-th waiting cycle of a tile.
  localparam logic [WW-1:0] WD_LAST = WW'(TIMEOUT_CYC - 1);

  logic          err_q, err_d;
  logic [WW-1:0] wd_q,  wd_d;
`else
  logic unused_timeout;
  assign unused_timeout = (TIMEOUT_CYC > 0);
`endif

  always_comb begin
    state_d      = state_q;
    tile_start_d = 1'b0;
    h_base_d     = h_base_q;
    p_base_d     = p_base_q;
    tile_cnt_d   = tile_cnt_q;
    busy_d       = busy_q;
    done_d       = 1'b0;
`ifdef SSM_TILE_TIMEOUT_EN
    err_d        = err_q;
    wd_d         = wd_q;
`endif

    case (state_q)
      S_IDLE: begin
        // tile_done and abort carry no meaning between passes.
        if (start) begin
          state_d      = S_WAIT;
          tile_start_d = 1'b1;
          busy_d       = 1'b1;
          h_base_d     = '0;
          p_base_d     = '0;
          tile_cnt_d   = '0;
`ifdef SSM_TILE_TIMEOUT_EN
          err_d        = 1'b0;
          wd_d         = '0;
`endif
        end
      end

      S_WAIT: begin
        if (abort) begin
          // Cancel wins over a tile finishing in the same cycle; the
          // completed-tile count is left for software to inspect.
          state_d  = S_IDLE;
          busy_d   = 1'b0;
          h_base_d = '0;
          p_base_d = '0;
        end else if (tile_done) begin
          tile_cnt_d = tile_cnt_q + CW'(1);
`ifdef SSM_TILE_TIMEOUT_EN
          wd_d       = '0;
`endif
          if (tile_cnt_q == CNT_LAST) begin
            state_d = S_FIN;
            busy_d  = 1'b0;
            done_d  = 1'b1;
          end else begin
            tile_start_d = 1'b1;
            if (p_base_q == P_LAST) begin
              p_base_d = '0;
              h_base_d = h_base_q + H_STEP;
            end else begin
              p_base_d = p_base_q + P_STEP;
            end
          end
        end
`ifdef SSM_TILE_TIMEOUT_EN
        else if (wd_q == WD_LAST) begin
          err_d   = 1'b1;
          state_d = S_IDLE;
          busy_d  = 1'b0;
        end else begin
          wd_d = wd_q + WW'(1);
        end
`endif
      end

      S_FIN: begin
        // done is already on the wire this cycle; indices and count hold
        // their final values unless the pass is cancelled here.
        state_d = S_IDLE;
        if (abort) begin
          h_base_d = '0;
          p_base_d = '0;
        end
      end

      default: begin
        state_d = S_IDLE;
        busy_d  = 1'b0;
      end
    endcase
  end

  always_ff @(posedge clk or negedge rst) begin
    if (!rst) begin
      state_q      <= S_IDLE;
      tile_start_q <= 1'b0;
      h_base_q     <= '0;
      p_base_q     <= '0;
      tile_cnt_q   <= '0;
      busy_q       <= 1'b0;
      done_q       <= 1'b0;
`ifdef SSM_TILE_TIMEOUT_EN
      err_q        <= 1'b0;
      wd_q         <= '0;
`endif
    end else begin
      state_q      <= state_d;
      tile_start_q <= tile_start_d;
      h_base_q     <= h_base_d;
      p_base_q     <= p_base_d;
      tile_cnt_q   <= tile_cnt_d;
      busy_q       <= busy_d;
      done_q       <= done_d;
`ifdef SSM_TILE_TIMEOUT_EN
      err_q        <= err_d;
      wd_q         <= wd_d;
`endif
    end
  end

  assign tile_start = tile_start_q;
  assign h_base     = h_base_q;
  assign p_base     = p_base_q;
  assign tile_cnt   = tile_cnt_q;
  assign busy       = busy_q;
  assign done       = done_q;
`ifdef SSM_TILE_TIMEOUT_EN
  assign err        = err_q;
`else
  assign err        = 1'b0;
`endif

endmodule
`default_nettype wire

// File: tb/tb_ssm_tile_scheduler.sv
`default_nettype none
`timescale 1ns/1ps
// ============================================================================
// Module   : tb_ssm_tile_scheduler
// Purpose  : Self-checking bench for ssm_tile_scheduler. A reference model
//            derives, from per-tile engine latencies, the cycle of every
//            tile_start, the tile order, the done cycle and the running tile
//            count, and every cycle of every pass is compared against it.
// Revision : 1.0 - initial release
// ============================================================================
module tb_ssm_tile_scheduler;

  localparam int H   = 24;
  localparam int P   = 64;
  localparam int HT  = 12;
  localparam int PT  = 16;
  localparam int TO  = 20;
  localparam int PPT = P / PT;
  localparam int NT  = (H / HT) * PPT;

  logic       clk = 1'b0;
  logic       rst;
  logic       start;
  logic       abort;
  logic       tile_done;
  logic       tile_start;
  logic [4:0] h_base;
  logic [5:0] p_base;
  logic [3:0] tile_cnt;
  logic       busy;
  logic       done;
  logic       err;

  int n_cmp = 0;
  int n_bad = 0;

  always #5 clk = ~clk;

  ssm_tile_scheduler #(
    .H(H), .P(P), .H_tile(HT), .P_tile(PT), .TIMEOUT_CYC(TO)
  ) dut (
    .clk(clk), .rst(rst), .start(start), .abort(abort), .tile_done(tile_done),
    .tile_start(tile_start), .h_base(h_base), .p_base(p_base),
    .tile_cnt(tile_cnt), .busy(busy), .done(done), .err(err)
  );

  // One full pass. Cycle 0 carries the start request; the engine answers
  // tile i d[i] cycles after its tile_start (dmode 0: random 0..5, 1: 3,
  // 2: same cycle). abort_tile >= 0 cancels the pass in the cycle tile
  // abort_tile finishes. spurious adds tile_done/abort while idle.
  task automatic run_pass(input string tag, input int dmode, input bit hold_start,
                          input int abort_tile, input bit spurious, input bit err0);
    int d[NT];
    int ts[NT];
    int comp[NT];
    int done_cyc, ab, last, cnt, cur, eh, ep, lim;
    bit aborted, ets, ebusy, edone, eerr, etd;
    for (int i = 0; i < NT; i++) begin
      if (dmode == 0)      d[i] = int'($urandom_range(0, 5));
      else if (dmode == 1) d[i] = 3;
      else                 d[i] = 0;
    end
    ts[0] = 1;
    for (int i = 0; i < NT; i++) begin
      comp[i] = ts[i] + d[i];
      if (i < NT - 1) ts[i+1] = comp[i] + 1;
    end
    done_cyc = comp[NT-1] + 1;
    ab   = (abort_tile >= 0) ? comp[abort_tile] : -1;
    last = (ab >= 0) ? ab + 4 : done_cyc + 3;
    for (int n = 0; n <= last; n++) begin
      start = hold_start ? (n <= done_cyc) : (n == 0);
      etd = 1'b0;
      for (int i = 0; i < NT; i++)
        if (comp[i] == n && (ab < 0 || n <= ab)) etd = 1'b1;
      if (spurious && (n == 0 || n == done_cyc + 1)) etd = 1'b1;
      tile_done = etd;
      abort = (n == ab) || (spurious && n == 0);
      @(negedge clk);
      aborted = (ab >= 0) && (n > ab);
      ets = 1'b0;
      for (int i = 0; i < NT; i++)
        if (ts[i] == n && !aborted) ets = 1'b1;
      ebusy = !aborted && n >= 1 && n < done_cyc;
      edone = (ab < 0) && (n == done_cyc);
      eerr  = (n == 0) ? err0 : 1'b0;
      lim   = aborted ? ab : n;
      cnt   = 0;
      for (int i = 0; i < NT; i++)
        if (comp[i] < lim) cnt++;
      cur = (cnt < NT) ? cnt : NT - 1;
      eh  = aborted ? 0 : (cur / PPT) * HT;
      ep  = aborted ? 0 : (cur % PPT) * PT;
      n_cmp++;
      if (tile_start !== ets) begin
        n_bad++;
        $display("FAIL %s cyc%0d tile_start: got %b want %b", tag, n, tile_start, ets);
      end
      n_cmp++;
      if (busy !== ebusy) begin
        n_bad++;
        $display("FAIL %s cyc%0d busy: got %b want %b", tag, n, busy, ebusy);
      end
      n_cmp++;
      if (done !== edone) begin
        n_bad++;
        $display("FAIL %s cyc%0d done: got %b want %b", tag, n, done, edone);
      end
      n_cmp++;
      if (err !== eerr) begin
        n_bad++;
        $display("FAIL %s cyc%0d err: got %b want %b", tag, n, err, eerr);
      end
      if (n >= 1) begin
        n_cmp++;
        if (tile_cnt !== 4'(cnt)) begin
          n_bad++;
          $display("FAIL %s cyc%0d tile_cnt: got %0d want %0d", tag, n, tile_cnt, cnt);
        end
        n_cmp++;
        if (h_base !== 5'(eh) || p_base !== 6'(ep)) begin
          n_bad++;
          $display("FAIL %s cyc%0d base: got (%0d,%0d) want (%0d,%0d)",
                   tag, n, h_base, p_base, eh, ep);
        end
      end
      @(posedge clk); #1;
    end
    start = 1'b0; tile_done = 1'b0; abort = 1'b0;
  endtask

  task automatic test_reset();
    rst = 1'b0; start = 1'b0; abort = 1'b0; tile_done = 1'b0;
    repeat (2) @(posedge clk);
    @(negedge clk);
    n_cmp++;
    if ({tile_start, h_base, p_base, tile_cnt, busy, done, err} !== 20'd0) begin
      n_bad++;
      $display("FAIL reset outputs: got %b want all zero",
               {tile_start, h_base, p_base, tile_cnt, busy, done, err});
    end
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_fixed_latency();
    run_pass("lat3", 1, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_same_cycle_done();
    run_pass("same_cycle", 2, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_random_passes();
    for (int k = 0; k < 3; k++) run_pass("random", 0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_start_held();
    run_pass("start_held", 0, 1'b1, -1, 1'b1, 1'b0);
  endtask

  task automatic test_abort();
    run_pass("abort", 0, 1'b0, 3, 1'b0, 1'b0);
    run_pass("restart", 0, 1'b0, -1, 1'b0, 1'b0);
  endtask

  task automatic test_async_reset();
    start = 1'b1;
    @(posedge clk); #1;
    start = 1'b0; tile_done = 1'b1;
    repeat (3) begin @(posedge clk); #1; end
    tile_done = 1'b0;
    @(negedge clk);
    n_cmp++;
    if (busy !== 1'b1 || tile_cnt !== 4'd3 || p_base !== 6'd48) begin
      n_bad++;
      $display("FAIL async_reset pre-state: got busy=%b cnt=%0d p=%0d want busy=1 cnt=3 p=48",
               busy, tile_cnt, p_base);
    end
    #2 rst = 1'b0;
    #1;
    n_cmp++;
    if ({tile_start, h_base, p_base, tile_cnt, busy, done, err} !== 20'd0) begin
      n_bad++;
      $display("FAIL async_reset outputs: got %b want all zero",
               {tile_start, h_base, p_base, tile_cnt, busy, done, err});
    end
    @(negedge clk);
    rst = 1'b1;
    @(posedge clk); #1;
  endtask

  task automatic test_stall();
    bit ebusy, eerr, ets;
`ifdef SSM_TILE_TIMEOUT_EN
    for (int n = 0; n <= TO + 5; n++) begin
      start = (n == 0);
      @(negedge clk);
      ebusy = (n >= 1) && (n <= TO);
      eerr  = (n > TO);
`else
    for (int n = 0; n <= 45; n++) begin
      start = (n == 0);
      abort = (n == 40);
      @(negedge clk);
      ebusy = (n >= 1) && (n <= 40);
      eerr  = 1'b0;
`endif
      ets = (n == 1);
      n_cmp++;
      if (busy !== ebusy || err !== eerr || tile_start !== ets || done !== 1'b0) begin
        n_bad++;
        $display("FAIL stall cyc%0d: got busy=%b err=%b ts=%b done=%b want busy=%b err=%b ts=%b done=0",
                 n, busy, err, tile_start, done, ebusy, eerr, ets);
      end
      n_cmp++;
      if (tile_cnt !== 4'd0) begin
        n_bad++;
        $display("FAIL stall cyc%0d tile_cnt: got %0d want 0", n, tile_cnt);
      end
      @(posedge clk); #1;
    end
    start = 1'b0; abort = 1'b0;
`ifdef SSM_TILE_TIMEOUT_EN
    run_pass("after_timeout", 0, 1'b0, -1, 1'b0, 1'b1);
`else
    run_pass("after_stall", 0, 1'b0, -1, 1'b0, 1'b0);
`endif
  endtask

  initial begin
    test_reset();
    test_fixed_latency();
    test_same_cycle_done();
    test_random_passes();
    test_start_held();
    test_abort();
    test_async_reset();
    test_stall();
    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_bad);
    $finish;
  end

endmodule
`default_nettype wire
